// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding load/store slave with byte-lane writes plus a read-only debug port.
// Latency: resp_valid sampled high LATENCY edges after accept; dbg_rdata 1 cycle after dbg_addr.
// Backpressure: req_ready only in IDLE; RESP holds rdata/write stable until resp_ready.
//
// Ports: clk/reset (sync, active-high); req_valid/req_ready/req_addr/req_wen/req_wdata request side;
//        resp_valid/resp_ready/resp_rdata/resp_write response side; dbg_addr -> dbg_rdata display port.
module dmem_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_wen,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_write,
    input  logic [31:0] dbg_addr,
    output logic [31:0] dbg_rdata
);

    localparam int DEPTH = 1 << ADDR_W;
    // WAIT spends CNT_LOAD+1 cycles, so the response appears LATENCY edges after accept.
    localparam logic [3:0] CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("dmem_responder: LATENCY must be in 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic [3:0]        cnt_nxt;
    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] req_idx;
    logic [ADDR_W-1:0] dbg_idx;
    logic              accept;
    logic              unused_addr_bits;

    // Upper address bits alias; byte offset is ignored.
    assign req_idx = req_addr[ADDR_W+1:2];
    assign dbg_idx = dbg_addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{req_addr[1:0], req_addr[31:ADDR_W+2],
                                dbg_addr[1:0], dbg_addr[31:ADDR_W+2]};

    // Gated by reset so a pending response vanishes and no request is taken while reset is high.
    assign req_ready  = (state == S_IDLE) && !reset;
    assign resp_valid = (state == S_RESP) && !reset;
    assign accept     = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_nxt = S_RESP;
                    end else begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = CNT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = S_RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Storage is never cleared; only enabled lanes change.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < 4; i++) begin
                if (req_wen[i]) begin
                    mem[req_idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read data is captured at accept so it sees all earlier writes, then held through RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_rdata <= 32'd0;
            resp_write <= 1'b0;
        end else if (accept) begin
            resp_rdata <= (req_wen == 4'b0000) ? mem[req_idx] : 32'd0;
            resp_write <= |req_wen;
        end
    end

    // Non-blocking read of mem: a same-edge write is not visible here until the next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            dbg_rdata <= 32'd0;
        end else begin
            dbg_rdata <= mem[dbg_idx];
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int ADDR_W = 8;
    localparam int LAT    = 2;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [3:0]  req_wen;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_write;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_wen    (req_wen),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_write (resp_write),
        .dbg_addr   (dbg_addr),
        .dbg_rdata  (dbg_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One request/response; inputs driven and outputs sampled on the falling edge.
    task automatic transact(input string tag, input logic [31:0] addr, input logic [3:0] wen,
                            input logic [31:0] wdata, input logic [31:0] exp_rdata, input int stall);
        int cyc;
        @(negedge clk);
        check({tag, "/ready_before"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_addr  = addr;
        req_wen   = wen;
        req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
        while (!resp_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "/latency"}, 32'(cyc), 32'(LAT));
        check({tag, "/rdata"}, resp_rdata, exp_rdata);
        check({tag, "/write"}, 32'(resp_write), (wen != 4'b0000) ? 32'd1 : 32'd0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, "/stall_valid"}, 32'(resp_valid), 32'd1);
            check({tag, "/stall_rdata"}, resp_rdata, exp_rdata);
            check({tag, "/stall_ready"}, 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check({tag, "/valid_after"}, 32'(resp_valid), 32'd0);
        check({tag, "/ready_after"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_addr   = 32'd0;
        req_wen    = 4'd0;
        req_wdata  = 32'd0;
        resp_ready = 1'b0;
        dbg_addr   = 32'd0;

        // Reset held 3 cycles.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst/resp_valid", 32'(resp_valid), 32'd0);
            check("rst/dbg_rdata", dbg_rdata, 32'd0);
            check("rst/req_ready", 32'(req_ready), 32'd0);
            check("rst/resp_rdata", resp_rdata, 32'd0);
        end
        reset = 1'b0;
        #1;
        check("rst/ready_release", 32'(req_ready), 32'd1);

        // Write then read.
        transact("wr10", 32'h10, 4'hF, 32'hDEADBEEF, 32'd0, 0);
        transact("rd10", 32'h10, 4'h0, 32'd0, 32'hDEADBEEF, 0);

        // Byte lanes.
        transact("wr20", 32'h20, 4'hF, 32'h11223344, 32'd0, 0);
        transact("wr20_lanes", 32'h20, 4'b0101, 32'hAABBCCDD, 32'd0, 0);
        transact("rd20", 32'h23, 4'h0, 32'd0, 32'h11BB33DD, 0);

        // Backpressure: 5 stalled cycles in RESP.
        transact("bp", 32'h20, 4'h0, 32'd0, 32'h11BB33DD, 5);

        // Reset while in WAIT.
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 32'h30;
        req_wen   = 4'hF;
        req_wdata = 32'h5A5A5A5A;
        @(negedge clk);
        req_valid = 1'b0;
        reset     = 1'b1;
        check("rstwait/valid0", 32'(resp_valid), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rstwait/valid_rst", 32'(resp_valid), 32'd0);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rstwait/valid_post", 32'(resp_valid), 32'd0);
            check("rstwait/ready_post", 32'(req_ready), 32'd1);
        end
        transact("rd30", 32'h30, 4'h0, 32'd0, 32'h5A5A5A5A, 0);

        // Debug port and aliasing: 0x404 -> word 1, 0x410 -> word 4.
        transact("wr404", 32'h404, 4'hF, 32'hCAFE0001, 32'd0, 0);
        @(negedge clk);
        dbg_addr = 32'h004;
        @(negedge clk);
        check("dbg/alias", dbg_rdata, 32'hCAFE0001);
        transact("rd004", 32'h004, 4'h0, 32'd0, 32'hCAFE0001, 0);
        transact("rd410_wrap", 32'h410, 4'h0, 32'd0, 32'hDEADBEEF, 0);

        // Same-edge write and debug read of word 1.
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 32'h004;
        req_wen   = 4'hF;
        req_wdata = 32'h12345678;
        @(negedge clk);
        req_valid = 1'b0;
        check("dbg/same_edge_old", dbg_rdata, 32'hCAFE0001);
        @(negedge clk);
        check("dbg/next_new", dbg_rdata, 32'h12345678);
        cyc = 0;
        while (!resp_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("dbg/wr_resp_valid", 32'(resp_valid), 32'd1);
        check("dbg/wr_resp_write", 32'(resp_write), 32'd1);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("dbg/ready_after", 32'(req_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
